// File: rtl/writeback_arbiter_if.sv
// Bundles the execute-unit result handshakes and the writeback bus between
// the execute units (master) and the writeback arbiter (slave).
interface writeback_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int PREG_W  = 6,
    parameter int ROB_W   = 5
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*PREG_W-1:0] req_dst_preg;
    logic [NUM_REQ*XLEN-1:0]   req_val;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_idx;
    logic [NUM_REQ-1:0]        req_br_mispred;

    logic                      wb_valid;
    logic [PREG_W-1:0]         wb_dst_preg;
    logic [XLEN-1:0]           wb_val;
    logic [ROB_W-1:0]          wb_rob_idx;
    logic                      wb_br_mispred;
    logic [SRC_W-1:0]          wb_src;

    modport master (
        output req_valid, req_dst_preg, req_val, req_rob_idx, req_br_mispred,
        input  req_ready,
        input  wb_valid, wb_dst_preg, wb_val, wb_rob_idx, wb_br_mispred, wb_src
    );

    modport slave (
        input  req_valid, req_dst_preg, req_val, req_rob_idx, req_br_mispred,
        output req_ready,
        output wb_valid, wb_dst_preg, wb_val, wb_rob_idx, wb_br_mispred, wb_src
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-unit result FIFOs drained one packet per cycle by a round-robin arbiter
// onto the registered writeback / forwarding / ROB-completion bus.
module writeback_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int BUF_DEPTH = 2,
    parameter int XLEN      = 32,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 5
) (
    input logic               clk,
    input logic               rst,
    input logic               flush,
    writeback_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   val;
        logic [ROB_W-1:0]  rob;
        logic              br;
    } pkt_t;

    pkt_t             mem    [NUM_REQ][BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr [NUM_REQ];
    logic [PTR_W-1:0] wr_ptr [NUM_REQ];
    logic [CNT_W-1:0] count  [NUM_REQ];
    pkt_t             in_pkt [NUM_REQ];
    logic [SRC_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    pkt_t               head;

    logic               wb_valid_q;
    pkt_t               wb_pkt_q;
    logic [SRC_W-1:0]   wb_src_q;

    // Ready depends only on the stored count, so a full FIFO refuses a push even when popped.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i]  = (count[i] != CNT_W'(BUF_DEPTH));
            in_pkt[i] = '{preg: bus.req_dst_preg[i*PREG_W +: PREG_W],
                          val:  bus.req_val[i*XLEN +: XLEN],
                          rob:  bus.req_rob_idx[i*ROB_W +: ROB_W],
                          br:   bus.req_br_mispred[i]};
        end
    end

    assign push = bus.req_valid & ready;

    // Scan starting just after the last winner so every non-empty FIFO wins within NUM_REQ cycles.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_valid && count[cand] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = grant_valid && (grant_idx == SRC_W'(i));
        end
    end

    assign head = mem[grant_idx][rd_ptr[grant_idx]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= SRC_W'(NUM_REQ - 1);
            wb_valid_q <= 1'b0;
            wb_pkt_q   <= '0;
            wb_src_q   <= '0;
        end else if (flush) begin
            // Flush drops buffered and incoming packets but keeps fairness history.
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            wb_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_pkt[i];
                    wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            wb_valid_q <= grant_valid;
            if (grant_valid) begin
                wb_pkt_q <= head;
                wb_src_q <= grant_idx;
                rr_ptr   <= grant_idx;
            end
        end
    end

    assign bus.req_ready     = ready;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_dst_preg   = wb_pkt_q.preg;
    assign bus.wb_val        = wb_pkt_q.val;
    assign bus.wb_rob_idx    = wb_pkt_q.rob;
    assign bus.wb_br_mispred = wb_pkt_q.br;
    assign bus.wb_src        = wb_src_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench: a queue-based model predicts every writeback packet and
// a negedge monitor compares it with the bus, alongside directed scenarios.
module tb_writeback_arbiter;
    localparam int NUM_REQ   = 3;
    localparam int BUF_DEPTH = 2;
    localparam int XLEN      = 32;
    localparam int PREG_W    = 6;
    localparam int ROB_W     = 5;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    writeback_arbiter_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

    writeback_arbiter #(
        .NUM_REQ(NUM_REQ), .BUF_DEPTH(BUF_DEPTH), .XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   val;
        logic [ROB_W-1:0]  rob;
        logic              br;
    } pkt_t;

    typedef struct {
        pkt_t p;
        int   src;
    } exp_t;

    pkt_t mq [NUM_REQ][$];
    exp_t exp_q [$];
    int   rr;
    bit   model_live = 1'b0;
    bit   model_wb_valid = 1'b0;
    pkt_t last_p;
    int   last_src;
    bit   accepted [NUM_REQ];
    bit   was_rdy [NUM_REQ];
    int   g;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   src0_hits = 0;
    exp_t mon_e;
    logic [NUM_REQ-1:0] exp_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: per-unit queues, round-robin choice over non-empty queues.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) accepted[i] = 1'b0;
        model_wb_valid = 1'b0;
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
            rr         = NUM_REQ - 1;
            last_p     = '{default: 0};
            last_src   = 0;
            model_live = 1'b1;
        end else if (flush) begin
            for (int i = 0; i < NUM_REQ; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NUM_REQ; i++) was_rdy[i] = (mq[i].size() < BUF_DEPTH);
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (g < 0 && mq[(rr + k) % NUM_REQ].size() > 0) g = (rr + k) % NUM_REQ;
            end
            if (g >= 0) begin
                last_p   = mq[g].pop_front();
                last_src = g;
                rr       = g;
                exp_q.push_back('{last_p, g});
                model_wb_valid = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && was_rdy[i]) begin
                    mq[i].push_back('{bus.req_dst_preg[i*PREG_W +: PREG_W],
                                      bus.req_val[i*XLEN +: XLEN],
                                      bus.req_rob_idx[i*ROB_W +: ROB_W],
                                      bus.req_br_mispred[i]});
                    accepted[i] = 1'b1;
                end
            end
        end
    end

    // Monitor: pops an expected packet whenever the DUT presents one.
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < NUM_REQ; i++) exp_rdy[i] = (mq[i].size() < BUF_DEPTH);
            check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("wb_valid", 64'(bus.wb_valid), 64'(model_wb_valid));
            if (bus.wb_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL wb_unexpected: got packet val 0x%0h, expected none at %0t",
                             bus.wb_val, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_dst_preg", 64'(bus.wb_dst_preg), 64'(mon_e.p.preg));
                    check("wb_val", 64'(bus.wb_val), 64'(mon_e.p.val));
                    check("wb_rob_idx", 64'(bus.wb_rob_idx), 64'(mon_e.p.rob));
                    check("wb_br_mispred", 64'(bus.wb_br_mispred), 64'(mon_e.p.br));
                    check("wb_src", 64'(bus.wb_src), 64'(mon_e.src));
                    if (bus.wb_src == '0) src0_hits++;
                end
            end else begin
                if (model_wb_valid && exp_q.size() > 0) void'(exp_q.pop_front());
                check("hold_dst_preg", 64'(bus.wb_dst_preg), 64'(last_p.preg));
                check("hold_val", 64'(bus.wb_val), 64'(last_p.val));
                check("hold_rob_idx", 64'(bus.wb_rob_idx), 64'(last_p.rob));
                check("hold_src", 64'(bus.wb_src), 64'(last_src));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid      = '0;
        bus.req_dst_preg   = '0;
        bus.req_val        = '0;
        bus.req_rob_idx    = '0;
        bus.req_br_mispred = '0;
        flush              = 1'b0;
    endtask

    task automatic apply_stimulus(input int unit, input logic [PREG_W-1:0] preg,
                                  input logic [XLEN-1:0] val, input logic [ROB_W-1:0] rob,
                                  input logic br);
        bus.req_valid[unit]                   = 1'b1;
        bus.req_dst_preg[unit*PREG_W +: PREG_W] = preg;
        bus.req_val[unit*XLEN +: XLEN]        = val;
        bus.req_rob_idx[unit*ROB_W +: ROB_W]  = rob;
        bus.req_br_mispred[unit]              = br;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'(0));
        check({tag, "_wb_dst_preg"}, 64'(bus.wb_dst_preg), 64'(0));
        check({tag, "_wb_val"}, 64'(bus.wb_val), 64'(0));
        check({tag, "_wb_rob_idx"}, 64'(bus.wb_rob_idx), 64'(0));
        check({tag, "_wb_br"}, 64'(bus.wb_br_mispred), 64'(0));
        check({tag, "_wb_src"}, 64'(bus.wb_src), 64'(0));
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(3'b111));
    endtask

    int seq [NUM_REQ];
    bit saw_low;

    initial begin
        clear_inputs();

        do_reset();
        check_reset_state("reset");

        // Single push from unit 1, 2-cycle latency.
        for (int c = 0; c < 10; c++) tick();
        apply_stimulus(1, 6'd5, 32'hDEADBEEF, 5'd3, 1'b0);
        tick();
        clear_inputs();
        check("single_t1_valid", 64'(bus.wb_valid), 64'(0));
        tick();
        check("single_t2_valid", 64'(bus.wb_valid), 64'(1));
        check("single_dst", 64'(bus.wb_dst_preg), 64'(5));
        check("single_val", 64'(bus.wb_val), 64'(32'hDEADBEEF));
        check("single_rob", 64'(bus.wb_rob_idx), 64'(3));
        check("single_src", 64'(bus.wb_src), 64'(1));
        tick();
        check("single_t3_valid", 64'(bus.wb_valid), 64'(0));

        // Contention right after reset: unit 0 first, then 1, then 2.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 6'(10 + i), 32'(100 + i), 5'(i), 1'b0);
        tick();
        clear_inputs();
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            check("contend_valid", 64'(bus.wb_valid), 64'(1));
            check("contend_src", 64'(bus.wb_src), 64'(i));
            tick();
        end
        check("contend_idle", 64'(bus.wb_valid), 64'(0));

        // Backpressure: all units push continuously with sequential values.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 1;
        saw_low = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c == 20) src0_hits = 0;
            if (c == 50) check("bp_unit0_share", 64'(src0_hits), 64'(10));
            if (!bus.req_ready[0]) saw_low = 1'b1;
            for (int i = 0; i < NUM_REQ; i++)
                apply_stimulus(i, 6'($urandom_range(0, 63)), 32'(seq[i]), 5'(i), 1'b0);
            tick();
            for (int i = 0; i < NUM_REQ; i++) if (accepted[i]) seq[i]++;
        end
        check("bp_ready0_dropped", 64'(saw_low), 64'(1));
        clear_inputs();
        for (int c = 0; c < 8; c++) tick();

        // Flush with buffered packets plus a push in the flush cycle.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 6'(20 + i), 32'(32'hA0 + i), 5'(i), 1'b0);
        tick();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 6'(30 + i), 32'(32'hB0 + i), 5'(i), 1'b1);
        tick();
        clear_inputs();
        flush = 1'b1;
        apply_stimulus(2, 6'd40, 32'hC0, 5'd9, 1'b0);
        tick();
        clear_inputs();
        check("flush_next_valid", 64'(bus.wb_valid), 64'(0));
        check("flush_next_ready", 64'(bus.req_ready), 64'(3'b111));
        apply_stimulus(1, 6'd9, 32'h1234, 5'd7, 1'b1);
        tick();
        clear_inputs();
        check("flush_push_t1", 64'(bus.wb_valid), 64'(0));
        tick();
        check("flush_push_t2", 64'(bus.wb_valid), 64'(1));
        check("flush_push_val", 64'(bus.wb_val), 64'(32'h1234));
        check("flush_push_br", 64'(bus.wb_br_mispred), 64'(1));
        check("flush_push_src", 64'(bus.wb_src), 64'(1));
        for (int c = 0; c < 4; c++) tick();

        // Reset mid-stream with two packets buffered.
        do_reset();
        apply_stimulus(0, 6'd1, 32'h55, 5'd1, 1'b1);
        apply_stimulus(1, 6'd2, 32'h66, 5'd2, 1'b1);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("midrst_no_stale", 64'(bus.wb_valid), 64'(0));
        end

        // Unit 2 full while being popped: push refused, then accepted on retry.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 6'(i), 32'(32'hA2 + i), 5'(i), 1'b0);
        tick();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 6'(i), 32'(32'hB2 + i), 5'(i), 1'b0);
        tick();
        clear_inputs();
        apply_stimulus(2, 6'd12, 32'hC2, 5'd12, 1'b0);
        check("full_c_ready2", 64'(bus.req_ready[2]), 64'(0));
        tick();
        check("full_d_ready2", 64'(bus.req_ready[2]), 64'(0));
        tick();
        check("full_e_ready2", 64'(bus.req_ready[2]), 64'(1));
        tick();
        clear_inputs();
        for (int c = 0; c < 6; c++) tick();

        // Randomized traffic with occasional flush and reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 99) < 60)
                    apply_stimulus(i, 6'($urandom), $urandom, 5'($urandom), 1'($urandom));
            end
            flush = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        clear_inputs();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
